// File: rtl/vortex_mem_pkg.sv
// Shared types and line geometry for the Vortex memory interface.
// Used by the master bridge and the line word packer.
package vortex_mem_pkg;
  localparam int LINE_BYTES     = 64;
  localparam int WORDS_PER_LINE = 16;
  localparam int MEM_ADDR_W     = 26;
  localparam int MEM_DATA_W     = 512;
  localparam int MEM_BYTEEN_W   = 64;
  localparam int MEM_TAG_W      = 56;

  typedef logic [3:0] word_in_512_t;
  typedef logic [5:0] byte_in_512_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    RESP
  } state_t;
endpackage

// File: rtl/vortex_line_word_pack.sv
// Packs one 32-bit word into a 512-bit line (replicated data, byte enables)
// and extracts one word from a returned line.
module vortex_line_word_pack
  import vortex_mem_pkg::*;
(
  input  word_in_512_t            word_sel,
  input  logic [31:0]             wdata,
  input  logic [3:0]              strobe,
  input  logic [MEM_DATA_W-1:0]   line,
  output logic [MEM_DATA_W-1:0]   line_data,
  output logic [MEM_BYTEEN_W-1:0] line_byteen,
  output logic [31:0]             rd_word
);
  always_comb begin
    line_data   = '0;
    line_byteen = '0;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      line_data[w*32 +: 32] = wdata;
      if (word_in_512_t'(w) == word_sel)
        line_byteen[w*4 +: 4] = strobe;
    end
  end

  assign rd_word = line[{word_sel, 5'b0} +: 32];
endmodule

// File: rtl/vortex_mem_master_bridge.sv
// Word-command initiator for the Vortex memory interface: one
// outstanding line request, tag-matched read response, timeout.
module vortex_mem_master_bridge
  import vortex_mem_pkg::*;
#(
  parameter int TAG_SEQ_W      = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit ADDR_HI_CHECK  = 1'b0
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rw,
  input  logic [31:0]             cmd_addr,
  input  logic [31:0]             cmd_wdata,
  input  logic [3:0]              cmd_strobe,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [31:0]             res_rdata,
  output logic                    res_error,
  output logic                    mem_req_valid,
  output logic                    mem_req_rw,
  output logic [MEM_BYTEEN_W-1:0] mem_req_byteen,
  output logic [MEM_ADDR_W-1:0]   mem_req_addr,
  output logic [MEM_DATA_W-1:0]   mem_req_data,
  output logic [MEM_TAG_W-1:0]    mem_req_tag,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [MEM_DATA_W-1:0]   mem_rsp_data,
  input  logic [MEM_TAG_W-1:0]    mem_rsp_tag,
  output logic                    mem_rsp_ready
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t               state, state_d;
  logic [TAG_SEQ_W-1:0] tag_seq, tag_seq_d;
  logic [TAG_SEQ_W-1:0] tag_issued;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 rw_q, rw_d;
  logic [31:2]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           strobe_q, strobe_d;
  logic [31:0]          rdata_d;
  logic                 err_d;
  logic                 in_req, tag_hit, addr_bad;

  logic [MEM_DATA_W-1:0]   pk_data;
  logic [MEM_BYTEEN_W-1:0] pk_be;
  logic [31:0]             pk_word;

  vortex_line_word_pack u_pack (
    .word_sel    (addr_q[5:2]),
    .wdata       (wdata_q),
    .strobe      (strobe_q),
    .line        (mem_rsp_data),
    .line_data   (pk_data),
    .line_byteen (pk_be),
    .rd_word     (pk_word)
  );

  assign cmd_ready     = (state == IDLE) & ~RST;
  assign in_req        = (state == REQ);
  assign mem_rsp_ready = (state == WAIT_RSP);
  assign res_valid     = (state == RESP);

  // Request fields are zero outside REQ so idle/reset outputs read as 0
  assign mem_req_valid  = in_req;
  assign mem_req_rw     = in_req & rw_q;
  assign mem_req_addr   = in_req ? addr_q[31:6] : '0;
  assign mem_req_tag    = in_req ? MEM_TAG_W'(tag_seq) : '0;
  assign mem_req_data   = (in_req & rw_q) ? pk_data : '0;
  assign mem_req_byteen = in_req ? (rw_q ? pk_be : '1) : '0;

  assign tag_issued = tag_seq - TAG_SEQ_W'(1);
  assign tag_hit    = mem_rsp_valid
                    & (mem_rsp_tag[TAG_SEQ_W-1:0] == tag_issued)
                    & (mem_rsp_tag[MEM_TAG_W-1:TAG_SEQ_W] == '0);
  assign addr_bad   = (cmd_addr[1:0] != 2'b00)
                    | (ADDR_HI_CHECK & (cmd_addr[31:28] != 4'hF));

  always_comb begin
    state_d   = state;
    tag_seq_d = tag_seq;
    cnt_d     = cnt;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strobe_d  = strobe_q;
    rdata_d   = res_rdata;
    err_d     = res_error;
    unique case (state)
      IDLE: begin
        if (cmd_valid & cmd_ready) begin
          rw_d     = cmd_rw;
          addr_d   = cmd_addr[31:2];
          wdata_d  = cmd_wdata;
          strobe_d = cmd_strobe;
          if (addr_bad) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          tag_seq_d = tag_seq + TAG_SEQ_W'(1);
          cnt_d     = '0;
          state_d   = rw_q ? RESP : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt + CNT_W'(1);
        // A matching response beats a timeout in the same cycle
        if (tag_hit) begin
          rdata_d = pk_word;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      tag_seq   <= '0;
      cnt       <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strobe_q  <= '0;
      res_rdata <= '0;
      res_error <= 1'b0;
    end else begin
      state     <= state_d;
      tag_seq   <= tag_seq_d;
      cnt       <= cnt_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strobe_q  <= strobe_d;
      res_rdata <= rdata_d;
      res_error <= err_d;
    end
  end
endmodule

// File: tb/tb_vortex_mem_master_bridge.sv
// Scoreboard bench for vortex_mem_master_bridge with a behavioural
// line-memory slave (stalls, wrong tags, silence).
module tb_vortex_mem_master_bridge;
  import vortex_mem_pkg::*;

  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         RST = 1'b1;
  logic         cmd_valid, cmd_ready, cmd_rw;
  logic [31:0]  cmd_addr, cmd_wdata;
  logic [3:0]   cmd_strobe;
  logic         res_valid, res_ready, res_error;
  logic [31:0]  res_rdata;
  logic         mem_req_valid, mem_req_rw, mem_req_ready;
  logic [63:0]  mem_req_byteen;
  logic [25:0]  mem_req_addr;
  logic [511:0] mem_req_data;
  logic [55:0]  mem_req_tag;
  logic         mem_rsp_valid, mem_rsp_ready;
  logic [511:0] mem_rsp_data;
  logic [55:0]  mem_rsp_tag;

  vortex_mem_master_bridge #(
    .TAG_SEQ_W      (8),
    .TIMEOUT_CYCLES (TMO),
    .ADDR_HI_CHECK  (1'b1)
  ) dut (
    .clk            (clk),
    .RST            (RST),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_rw         (cmd_rw),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .cmd_strobe     (cmd_strobe),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_rdata      (res_rdata),
    .res_error      (res_error),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    bit          from_hs;
  } res_t;

  typedef struct {
    logic         rw;
    logic [25:0]  addr;
    logic [63:0]  be;
    logic [511:0] data;
    logic [55:0]  tag;
  } req_t;

  typedef struct {
    logic [511:0] data;
    logic [55:0]  tag;
  } rsp_t;

  res_t sb[$];
  req_t rq[$];
  rsp_t rsp_q[$];
  logic [31:0] ref_mem[logic [29:0]];
  logic [31:0] smem[logic [29:0]];

  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;
  int hs_cyc = 0;
  int smode = 0;
  int stall_cfg = 0;
  int req_cnt = 0;
  logic [7:0] tb_tag = 8'd0;

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave: decides ready/response at each falling edge
  initial begin : slave
    bit           in_req;
    int           stall_left;
    logic [146:0] snap;
    req_t         e;
    rsp_t         r;
    logic [511:0] line;
    logic [29:0]  wa;
    logic [31:0]  w;
    logic [5:0]   bi;
    in_req        = 0;
    stall_left    = 0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_tag   = '0;
    forever begin
      @(negedge clk);
      if (rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = r.data;
        mem_rsp_tag   = r.tag;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_tag   = '0;
      end
      if (mem_req_valid) begin
        if (!in_req) begin
          in_req = 1;
          req_cnt++;
          stall_left = stall_cfg;
          snap = {mem_req_tag, mem_req_addr, mem_req_byteen, mem_req_rw};
          if (rq.size() == 0) begin
            chk("req_extra", 1, 0);
          end else begin
            e = rq.pop_front();
            chk("req_rw", mem_req_rw, e.rw);
            chk("req_addr", mem_req_addr, e.addr);
            chk("req_byteen", mem_req_byteen, e.be);
            chk("req_data", mem_req_data, e.data);
            chk("req_tag", mem_req_tag, e.tag);
          end
        end else begin
          chk("req_stable",
              {mem_req_tag, mem_req_addr, mem_req_byteen, mem_req_rw}, snap);
        end
        if (stall_left > 0) begin
          mem_req_ready = 1'b0;
          stall_left--;
        end else begin
          mem_req_ready = 1'b1;
          in_req = 0;
          hs_cyc = cyc + 1;
          stall_cfg = 0;
          if (mem_req_rw) begin
            for (int b = 0; b < 64; b++) begin
              if (mem_req_byteen[b]) begin
                bi = 6'(b);
                wa = {mem_req_addr, bi[5:2]};
                w = smem.exists(wa) ? smem[wa] : 32'h0;
                w[{bi[1:0], 3'b0} +: 8] = mem_req_data[b*8 +: 8];
                smem[wa] = w;
              end
            end
          end else if (smode != 2) begin
            for (int k = 0; k < 16; k++) begin
              wa = {mem_req_addr, 4'(k)};
              line[k*32 +: 32] = smem.exists(wa) ? smem[wa] : 32'h0;
            end
            if (smode == 1)
              rsp_q.push_back('{{16{32'hBAD0BAD0}}, 56'h7F});
            rsp_q.push_back('{line, mem_req_tag});
          end
        end
      end else begin
        mem_req_ready = 1'b0;
        in_req = 0;
      end
    end
  end

  always @(negedge clk) begin : mon
    res_t e;
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("res_extra", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("res_error", res_error, e.err);
        chk("res_rdata", res_rdata, e.rdata);
        if (e.lat >= 0)
          chk("res_lat", e.from_hs ? cyc - hs_cyc : cyc - acc_cyc + 1, e.lat);
      end
    end
  end

  task automatic send(input logic rw, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] st,
                      input int lat, input bit from_hs);
    req_t        q;
    res_t        r;
    logic [29:0] wa;
    logic [31:0] w;
    int          n;
    wa        = addr[31:2];
    r.err     = 1'b0;
    r.rdata   = '0;
    r.lat     = lat;
    r.from_hs = from_hs;
    if (addr[1:0] != 2'b00 || addr[31:28] != 4'hF) begin
      r.err = 1'b1;
    end else begin
      q.rw   = rw;
      q.addr = addr[31:6];
      q.tag  = {48'b0, tb_tag};
      tb_tag = tb_tag + 8'd1;
      q.be   = '0;
      q.data = '0;
      if (rw) begin
        for (int i = 0; i < 16; i++) q.data[i*32 +: 32] = wd;
        for (int b = 0; b < 4; b++) q.be[addr[5:2]*4 + b] = st[b];
        w = ref_mem.exists(wa) ? ref_mem[wa] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (st[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        ref_mem[wa] = w;
      end else begin
        q.be = '1;
        if (smode == 2) r.err = 1'b1;
        else r.rdata = ref_mem.exists(wa) ? ref_mem[wa] : 32'h0;
      end
      rq.push_back(q);
    end
    sb.push_back(r);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_rw     = rw;
    cmd_addr   = addr;
    cmd_wdata  = wd;
    cmd_strobe = st;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_ready, 1);
    acc_cyc = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size() + rq.size(), 0);
    sb.delete();
    rq.delete();
    @(negedge clk);
  endtask

  initial begin
    int n0;
    cmd_valid  = 1'b0;
    cmd_rw     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    cmd_strobe = '0;
    res_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_rsp_ready", mem_rsp_ready, 0);
    chk("rst_res", {res_valid, res_error, res_rdata}, 0);
    RST = 1'b0;

    for (int k = 0; k < 16; k++) begin
      ref_mem[{26'h3C00001, 4'(k)}] = (k == 2) ? 32'h12345678
                                               : 32'hA5000000 | k;
      smem[{26'h3C00001, 4'(k)}] = ref_mem[{26'h3C00001, 4'(k)}];
    end

    send(1, 32'hF000_0044, 32'hDEADBEEF, 4'hF, 2, 0);
    drain();
    send(0, 32'hF000_0048, 32'h0, 4'h0, 3, 0);
    drain();
    send(1, 32'hF000_0044, 32'h11223344, 4'b0101, 2, 0);
    drain();
    stall_cfg = 5;
    send(0, 32'hF000_0044, 32'h0, 4'h0, -1, 0);
    drain();
    smode = 1;
    send(0, 32'hF000_004C, 32'h0, 4'h0, -1, 0);
    drain();
    smode = 2;
    send(0, 32'hF000_0050, 32'h0, 4'h0, TMO, 1);
    drain();
    smode = 0;

    n0 = req_cnt;
    send(0, 32'hF000_0002, 32'h0, 4'h0, -1, 0);
    drain();
    send(0, 32'h1000_0040, 32'h0, 4'h0, -1, 0);
    drain();
    chk("no_mem_req", req_cnt, n0);

    send(1, 32'hF000_00FC, 32'hCAFEF00D, 4'hF, 2, 0);
    drain();
    send(0, 32'hF000_00FC, 32'h0, 4'h0, 3, 0);
    drain();

    smode = 2;
    send(0, 32'hF000_0058, 32'h0, 4'h0, -1, 0);
    @(negedge clk);
    chk("in_wait_rsp", mem_rsp_ready, 1);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_rsp_ready", mem_rsp_ready, 0);
    chk("mid_rst_res", {res_valid, res_error, res_rdata}, 0);
    chk("mid_rst_req", {mem_req_valid, mem_req_rw, mem_req_addr,
                        mem_req_tag, mem_req_byteen, mem_req_data}, 0);
    sb.delete();
    rq.delete();
    rsp_q.delete();
    tb_tag = 8'd0;
    smode = 0;
    @(negedge clk);
    RST = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_cmd_ready", cmd_ready, 1);

    @(negedge clk);
    rsp_q.push_back('{{16{32'h5A5A5A5A}}, 56'h0});
    repeat (3) @(negedge clk);
    chk("stray_rsp_ignored", res_valid, 0);

    send(0, 32'hF000_0048, 32'h0, 4'h0, 3, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
